// File: rtl/instr_writer.sv
// Serialises one decoded arithmetic operation per handshake into consecutive
// 8-bit program-memory words (opcode, a, b). Optional: INSTR_WRITER_DIVZERO_CHECK_EN.
module instr_writer #(
  parameter int DEPTH = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_opcode,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic [7:0] word_count,
  output logic       full,
  output logic       err,
  output logic [1:0] err_code,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W_OP = 2'd1,
    W_A  = 2'd2,
    W_B  = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       three_q;

  logic       fire;
  logic       op_legal;
  logic       is_three;
  logic [8:0] op_len;
  logic       no_space;
  logic       div_zero;
  logic [1:0] rej_code;
  logic       reject;

  // Handshake: a request transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready never depends on in_valid.
  assign in_ready  = rst_n & (state == IDLE) & ~clr;
  assign fire      = in_valid & in_ready;
  assign fsm_state = state;

  assign op_legal = (in_opcode >= 8'h02) && (in_opcode <= 8'h08);
  assign is_three = (in_opcode <= 8'h06);
  assign op_len   = is_three ? 9'd3 : 9'd2;
  assign no_space = ({1'b0, word_count} + op_len) > 9'(DEPTH);
  assign full     = ({1'b0, word_count} + 9'd2) > 9'(DEPTH);

`ifdef INSTR_WRITER_DIVZERO_CHECK_EN
  assign div_zero = ((in_opcode == 8'h05) || (in_opcode == 8'h06)) && (in_b == 8'h00);
`else
  assign div_zero = 1'b0;
`endif

  // Priority: bad opcode, then space, then divide by zero.
  always_comb begin
    rej_code = 2'b00;
    if (!op_legal)     rej_code = 2'b01;
    else if (no_space) rej_code = 2'b10;
    else if (div_zero) rej_code = 2'b11;
  end

  assign reject = (rej_code != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= 8'h00;
      mem_wdata  <= 8'h00;
      word_count <= 8'h00;
      err        <= 1'b0;
      err_code   <= 2'b00;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      three_q    <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (clr) begin
            word_count <= 8'h00;
          end else if (fire) begin
            if (reject) begin
              err      <= 1'b1;
              err_code <= rej_code;
            end else begin
              err_code  <= 2'b00;
              mem_we    <= 1'b1;
              mem_addr  <= word_count;
              mem_wdata <= in_opcode;
              a_q       <= in_a;
              b_q       <= in_b;
              three_q   <= is_three;
              state     <= W_OP;
            end
          end
        end
        // word_count still holds the address being written this cycle.
        W_OP: begin
          word_count <= word_count + 8'd1;
          mem_addr   <= word_count + 8'd1;
          mem_wdata  <= a_q;
          state      <= W_A;
        end
        W_A: begin
          word_count <= word_count + 8'd1;
          if (three_q) begin
            mem_addr  <= word_count + 8'd1;
            mem_wdata <= b_q;
            state     <= W_B;
          end else begin
            mem_we <= 1'b0;
            state  <= IDLE;
          end
        end
        W_B: begin
          word_count <= word_count + 8'd1;
          mem_we     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_writer.sv
// Directed bench for instr_writer: write layout/timing, rejects, full/clr,
// divide-by-zero handling and asynchronous reset mid-operation.
module tb_instr_writer;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_opcode;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] word_count;
  logic       full;
  logic       err;
  logic [1:0] err_code;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int wc_model = 0;
  logic [15:0] exp_q[$];

  instr_writer #(.DEPTH(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .word_count (word_count),
    .full       (full),
    .err        (err),
    .err_code   (err_code),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every memory write is matched against the expected queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        check_eq("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  // driver: present one request, let it transfer on the next rising edge
  task automatic send(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    check_eq("ready_before", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_opcode = 8'($urandom_range(0, 255));
    in_a      = 8'($urandom_range(0, 255));
    in_b      = 8'($urandom_range(0, 255));
  endtask

  task automatic run_good(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int len);
    exp_q.push_back({8'(wc_model), op});
    exp_q.push_back({8'(wc_model + 1), a});
    if (len == 3) exp_q.push_back({8'(wc_model + 2), b});
    send(op, a, b);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      check_eq("we_in_write", mem_we, 1'b1);
      check_eq("ready_busy", in_ready, 1'b0);
      check_eq("wc_during", word_count, 32'(wc_model + k));
    end
    @(negedge clk);
    wc_model = wc_model + len;
    check_eq("we_after", mem_we, 1'b0);
    check_eq("ready_after", in_ready, 1'b1);
    check_eq("wc_after", word_count, 32'(wc_model));
    check_eq("err_code_ok", err_code, 2'b00);
    check_eq("full_after", full, (12 - wc_model) < 2);
  endtask

  task automatic run_bad(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] code);
    send(op, a, b);
    @(negedge clk);
    check_eq("err_pulse", err, 1'b1);
    check_eq("err_code", err_code, code);
    check_eq("we_reject", mem_we, 1'b0);
    check_eq("wc_reject", word_count, 32'(wc_model));
    @(negedge clk);
    check_eq("err_one_cycle", err, 1'b0);
    check_eq("err_code_hold", err_code, code);
    check_eq("we_reject2", mem_we, 1'b0);
    check_eq("ready_reject", in_ready, 1'b1);
  endtask

  task automatic do_clr_with_valid();
    @(negedge clk);
    clr       = 1'b1;
    in_valid  = 1'b1;
    in_opcode = 8'h02;
    in_a      = 8'h01;
    in_b      = 8'h01;
    #1;
    check_eq("ready_clr", in_ready, 1'b0);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    wc_model = 0;
    @(negedge clk);
    check_eq("wc_clr", word_count, 32'h0);
    check_eq("full_clr", full, 1'b0);
    check_eq("we_clr", mem_we, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in_opcode = 8'h00; in_a = 8'h00; in_b = 8'h00;
    #1;
    check_eq("ready_in_reset", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_we", mem_we, 1'b0);
    check_eq("rst_addr", mem_addr, 8'h00);
    check_eq("rst_wdata", mem_wdata, 8'h00);
    check_eq("rst_wc", word_count, 8'h00);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_err_code", err_code, 2'b00);
    check_eq("rst_full", full, 1'b0);
    check_eq("rst_ready", in_ready, 1'b1);

    run_good(8'h02, 8'h05, 8'h03, 3);   // ADD -> words 0..2
    run_good(8'h07, 8'hFF, 8'hAA, 2);   // INC -> words 3..4, b not written
    run_bad(8'h09, 8'h01, 8'h02, 2'b01);
    run_bad(8'h01, 8'h01, 8'h02, 2'b01);

    do_clr_with_valid();
    run_good(8'h04, 8'h10, 8'h10, 3);   // first accept clears the held err_code
    run_good(8'h04, 8'h10, 8'h10, 3);
    run_good(8'h04, 8'h10, 8'h10, 3);
    check_eq("full_at_9", full, 1'b0);
    run_good(8'h04, 8'h10, 8'h10, 3);
    check_eq("full_at_12", full, 1'b1);
    check_eq("wc_at_12", word_count, 8'd12);
    run_bad(8'h02, 8'h01, 8'h01, 2'b10);
    run_bad(8'h08, 8'h01, 8'h01, 2'b10);
    run_bad(8'h0F, 8'h01, 8'h01, 2'b01); // opcode check outranks space check
    do_clr_with_valid();

`ifdef INSTR_WRITER_DIVZERO_CHECK_EN
    run_bad(8'h05, 8'h20, 8'h00, 2'b11);
    run_bad(8'h06, 8'h20, 8'h00, 2'b11);
    run_good(8'h05, 8'h20, 8'h04, 3);
`else
    run_good(8'h05, 8'h20, 8'h00, 3);
    run_good(8'h06, 8'h20, 8'h00, 3);
`endif

    // asynchronous reset while the in_a word is being written
    exp_q.push_back({8'(wc_model), 8'h02});
    send(8'h02, 8'h11, 8'h22);
    @(negedge clk);
    check_eq("we_op_before_rst", mem_we, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_we", mem_we, 1'b0);
    check_eq("arst_addr", mem_addr, 8'h00);
    check_eq("arst_wdata", mem_wdata, 8'h00);
    check_eq("arst_wc", word_count, 8'h00);
    check_eq("arst_err", err, 1'b0);
    check_eq("arst_err_code", err_code, 2'b00);
    check_eq("arst_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wc_model = 0;
    @(negedge clk);
    check_eq("post_rst_ready", in_ready, 1'b1);
    check_eq("post_rst_wc", word_count, 8'h00);
    run_good(8'h02, 8'h33, 8'h44, 3);

    repeat (2) @(negedge clk);
    check_eq("exp_q_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
